// File: rtl/parity_pkg.sv
// Shared definitions for the word-parity path (generator and receiver sides).
// Contents:
//   parity_rx_state_e : receiver lock FSM states (RUN, LOCKED)
//   PARITY_MAX_W      : widest data word parity_err() accepts
//   parity_err()      : 1 when {data, par} fails the even/odd parity check
package parity_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    LOCKED = 1'b1
  } parity_rx_state_e;

  localparam int unsigned PARITY_MAX_W = 1024;

  // Callers zero-extend narrower words; zero bits leave the reduction unchanged.
  function automatic logic parity_err(input logic [PARITY_MAX_W-1:0] data,
                                      input logic par,
                                      input logic odd);
    return (^data) ^ par ^ odd;
  endfunction

endpackage

// File: rtl/parity_check_rx_if.sv
// Valid/ready stream bundle for parity_check_rx.
// Input side : in_valid, in_ready, in_data, in_parity
// Output side: out_valid, out_ready, out_data, out_err
// Modports: slave = the receiver, master = the party driving words in and
// consuming words out.
interface parity_check_rx_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport slave (
    input  in_valid, in_data, in_parity, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_data, in_parity, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/parity_rx_stage.sv
// One-entry valid/ready register slice carrying {data, err}.
// Ports:
//   clock, reset_n   : clock, async active-low reset (drops the held word)
//   s_valid/s_ready  : upstream handshake; s_ready does not depend on s_valid
//   s_data, s_err    : word and its error tag
//   m_valid/m_ready  : downstream handshake
//   m_data, m_err    : registered word, held while m_valid && !m_ready
module parity_rx_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_err
);

  assign s_ready = !m_valid || m_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) begin
        m_data <= s_data;
        m_err  <= s_err;
      end
    end
  end

endmodule

// File: rtl/parity_check_rx.sv
// Receive end of the word-parity path. Checks {data, parity} words in even or
// odd mode, forwards each word one cycle later with an error tag, counts
// errors (saturating), keeps a sticky error flag, and locks the input after
// ERR_LIMIT consecutive bad words until clear_err.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   odd_mode       : 0 = even parity, 1 = odd parity (per accepted word)
//   clear_err      : pulse; clears counters/sticky, leaves LOCKED
//   bus            : parity_check_rx_if.slave (in_* / out_* streams)
//   sticky_err     : set on any counted error
//   err_count      : total counted errors, saturating at all-ones
//   locked         : 1 while in LOCKED
// Build option: PARITY_DROP_EN -- bad words are counted but not forwarded,
// and out_err is then always 0.
module parity_check_rx
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 odd_mode,
  input  logic                 clear_err,
  parity_check_rx_if.slave     bus,
  output logic                 sticky_err,
  output logic [CNT_W-1:0]     err_count,
  output logic                 locked
);

  parity_rx_state_e  state, state_nxt;
  logic              alive;
  logic [7:0]        consec;
  logic              stage_ready;
  logic              accept;
  logic              word_err;
  logic              bad;
  logic              stage_valid;
  logic              stage_err;
  logic [DATA_W-1:0] in_word;

  // Holds in_ready low through reset without routing reset_n into the datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) alive <= 1'b0;
    else          alive <= 1'b1;
  end

  assign in_word      = bus.in_data;
  assign bus.in_ready = alive && (state == RUN) && stage_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign word_err     = parity_err(PARITY_MAX_W'(in_word), bus.in_parity, odd_mode);
  assign bad          = accept && word_err;
  assign locked       = (state == LOCKED);

`ifdef PARITY_DROP_EN
  assign stage_valid = accept && !word_err;
  assign stage_err   = 1'b0;
`else
  assign stage_valid = accept;
  assign stage_err   = word_err;
`endif

  parity_rx_stage #(
    .DATA_W (DATA_W)
  ) u_stage (
    .clock   (clock),
    .reset_n (reset_n),
    .s_valid (stage_valid),
    .s_ready (stage_ready),
    .s_data  (in_word),
    .s_err   (stage_err),
    .m_valid (bus.out_valid),
    .m_ready (bus.out_ready),
    .m_data  (bus.out_data),
    .m_err   (bus.out_err)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Lock on the bad accept that brings consec up to ERR_LIMIT; a same-cycle
  // clear_err wins, so that word neither counts nor locks.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (!clear_err && bad && (consec == 8'(ERR_LIMIT - 1)))
          state_nxt = LOCKED;
      end
      LOCKED: begin
        if (clear_err)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_count  <= '0;
      sticky_err <= 1'b0;
      consec     <= '0;
    end else if (clear_err) begin
      err_count  <= '0;
      sticky_err <= 1'b0;
      consec     <= '0;
    end else if (bad) begin
      if (err_count != '1)
        err_count <= err_count + 1'b1;
      sticky_err <= 1'b1;
      consec     <= consec + 1'b1;
    end else if (accept) begin
      consec <= '0;
    end
  end

endmodule
